// File: rtl/clm_enc_sched.sv
// Round-robin scheduler sharing one codeword encoder between N_REQ mask consumers.
// Each grant pairs one requester with one fresh random word; the word is zeroized after encoding.
module clm_enc_sched #(
    parameter int d     = 4,
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ack,
    input  logic             rnd_valid,
    input  logic [d-1:0]     rnd_data,
    output logic             rnd_ready,
    output logic [d-1:0]     enc_r,
    input  logic [8+d-1:0]   enc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8+d-1:0]   out_data,
    output logic [IDW-1:0]   out_id,
    output logic [15:0]      enc_count
);

    typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

    state_t           state;
    logic [d-1:0]     r_reg;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   gnt_sel;
    logic [IDW-1:0]   idx;
    logic [N_REQ-1:0] cand;
    logic             gnt_any;
    logic             fire;
    logic             grant;

    assign enc_r = r_reg;
    assign fire  = (state == HOLD) && out_ready;

    // The requester being acked this cycle must not win the same-cycle grant.
    always_comb begin
        cand = req_valid;
        if (fire) cand[out_id] = 1'b0;
    end

    // Walk from the farthest candidate back to rr_ptr+1 so the nearest one wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = '0;
        idx     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % N_REQ);
            if (cand[idx]) begin
                gnt_any = 1'b1;
                gnt_sel = idx;
            end
        end
    end

    assign grant     = rst_n && rnd_valid && gnt_any && ((state == IDLE) || fire);
    assign rnd_ready = grant;

    always_comb begin
        req_ack = '0;
        if (fire) req_ack[out_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r_reg     <= '0;
            rr_ptr    <= IDW'(N_REQ - 1);
            gnt_id    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            enc_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) state <= ENCODE;
                end
                ENCODE: begin
                    out_data  <= enc_out;
                    out_id    <= gnt_id;
                    out_valid <= 1'b1;
                    r_reg     <= '0;
                    if (enc_count != 16'hFFFF) enc_count <= enc_count + 16'd1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (fire) begin
                        out_valid <= 1'b0;
                        state     <= grant ? ENCODE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (grant) begin
                r_reg  <= rnd_data;
                gnt_id <= gnt_sel;
                rr_ptr <= gnt_sel;
            end
        end
    end

endmodule

// File: tb/tb_clm_enc_sched.sv
// Bench for clm_enc_sched: directed literal checks plus randomized traffic against
// a transaction-level model checked on every falling edge.
module tb_clm_enc_sched;

    localparam int D     = 4;
    localparam int N_REQ = 4;
    localparam int IDW   = 2;
    localparam int CW    = 8 + D;
    localparam logic [CW-1:0] M [4] = '{12'hFFF, 12'h000, 12'h000, 12'h000};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_REQ-1:0] req_valid = '0;
    logic [N_REQ-1:0] req_ack;
    logic             rnd_valid = 1'b0;
    logic [D-1:0]     rnd_data = '0;
    logic             rnd_ready;
    logic [D-1:0]     enc_r;
    logic [CW-1:0]    enc_out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    out_data;
    logic [IDW-1:0]   out_id;
    logic [15:0]      enc_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] enc(input logic [D-1:0] r);
        logic [CW-1:0] acc = '0;
        for (int j = 0; j < D; j++) if (r[j]) acc ^= M[j];
        return acc;
    endfunction

    assign enc_out = enc(enc_r);

    clm_enc_sched #(.d(D), .N_REQ(N_REQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ack(req_ack),
        .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
        .enc_r(enc_r), .enc_out(enc_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .enc_count(enc_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: at most one job in flight; age 0 is the encode cycle,
    // age >= 1 means the codeword is being offered.
    bit              m_busy = 0;
    int              m_age = 0;
    int              m_ptr = N_REQ - 1;
    int              m_id = 0;
    int              m_cnt = 0;
    logic [D-1:0]    m_r = '0;
    logic [CW-1:0]   m_data = '0;
    logic [N_REQ-1:0] last_ack = '0;
    bit              e_valid, e_fire, e_grant;
    int              pick, ix;
    logic [N_REQ-1:0] mask, e_ack;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_id", out_id, 0);
            chk("rst_enc_r", enc_r, 0);
            chk("rst_enc_count", enc_count, 0);
            chk("rst_req_ack", req_ack, 0);
            chk("rst_rnd_ready", rnd_ready, 0);
            m_busy = 0; m_age = 0; m_ptr = N_REQ - 1; m_id = 0; m_cnt = 0;
        end else begin
            e_valid = m_busy && (m_age >= 1);
            e_fire  = e_valid && out_ready;
            mask = req_valid;
            if (e_fire) mask[m_id] = 1'b0;
            pick = -1;
            for (int k = 1; k <= N_REQ; k++) begin
                ix = (m_ptr + k) % N_REQ;
                if (pick < 0 && mask[ix]) pick = ix;
            end
            e_grant = (!m_busy || e_fire) && rnd_valid && (pick >= 0);
            e_ack = '0;
            if (e_fire) e_ack[m_id] = 1'b1;
            chk("out_valid", out_valid, e_valid);
            if (e_valid) begin
                chk("out_data", out_data, m_data);
                chk("out_id", out_id, m_id);
            end
            chk("rnd_ready", rnd_ready, e_grant);
            chk("req_ack", req_ack, e_ack);
            chk("enc_r", enc_r, (m_busy && m_age == 0) ? m_r : '0);
            chk("enc_count", enc_count, m_cnt);
            if (m_busy && m_age == 0) begin
                m_age = 1;
                if (m_cnt < 16'hFFFF) m_cnt++;
            end else if (e_fire) begin
                m_busy = 0;
            end
            if (e_grant) begin
                m_busy = 1; m_age = 0; m_r = rnd_data;
                m_id = pick; m_ptr = pick; m_data = enc(rnd_data);
            end
        end
        last_ack = req_ack;
    end

    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    // One full service of a single requester from IDLE, with literal expectations.
    task automatic serve(input logic [3:0] req, input logic [3:0] rnd,
                         input logic [CW-1:0] exp_code, input int exp_id, input string tag);
        cyc();
        req_valid = req; rnd_valid = 1'b1; rnd_data = rnd; out_ready = 1'b0;
        smp(); chk({tag, "_grant_rnd_ready"}, rnd_ready, 1);
        cyc(); rnd_valid = 1'b0; rnd_data = 4'($urandom);
        smp(); chk({tag, "_enc_r"}, enc_r, rnd); chk({tag, "_early_valid"}, out_valid, 0);
        cyc();
        smp(); chk({tag, "_out_valid"}, out_valid, 1); chk({tag, "_out_data"}, out_data, exp_code);
        chk({tag, "_out_id"}, out_id, exp_id); chk({tag, "_no_ack"}, req_ack, 0);
        cyc(); out_ready = 1'b1;
        smp(); chk({tag, "_ack"}, req_ack, req);
        cyc(); req_valid = '0; out_ready = 1'b0;
        smp(); chk({tag, "_idle_valid"}, out_valid, 0); chk({tag, "_idle_enc_r"}, enc_r, 0);
    endtask

    int ids[5];
    int at[5];
    int nseen;
    logic [N_REQ-1:0] rq;

    initial begin
        smp(); smp();
        cyc(); rst_n = 1'b1;

        serve(4'b0100, 4'b0001, 12'hFFF, 2, "single");
        chk("single_enc_count", enc_count, 1);
        serve(4'b0001, 4'b1110, 12'h000, 0, "zero");

        // Round robin from a fresh pointer with all requesters held high.
        cyc(); rst_n = 1'b0;
        smp();
        cyc(); rst_n = 1'b1;
        req_valid = 4'hF; rnd_valid = 1'b1; out_ready = 1'b1;
        nseen = 0;
        for (int c = 0; c < 14; c++) begin
            rnd_data = 4'($urandom);
            smp();
            if (out_valid && nseen < 5) begin ids[nseen] = int'(out_id); at[nseen] = c; nseen++; end
            cyc();
        end
        chk("rr_count", nseen, 5);
        for (int i = 0; i < 5; i++) chk("rr_id", ids[i], i % 4);
        for (int i = 1; i < 5; i++) chk("rr_gap", at[i] - at[i-1], 2);
        req_valid = '0; rnd_valid = 1'b0;
        cyc(); cyc(); cyc();

        // Backpressure: hold the codeword five cycles while requester 0 waits.
        out_ready = 1'b0; req_valid = 4'b1000; rnd_valid = 1'b1; rnd_data = 4'b0011;
        smp(); chk("bp_grant", rnd_ready, 1);
        cyc(); req_valid = 4'b1001;
        smp();
        for (int i = 0; i < 5; i++) begin
            cyc(); smp();
            chk("bp_valid", out_valid, 1); chk("bp_data", out_data, 12'hFFF);
            chk("bp_id", out_id, 3); chk("bp_no_rnd", rnd_ready, 0); chk("bp_no_ack", req_ack, 0);
        end
        cyc(); out_ready = 1'b1;
        smp(); chk("bp_ack", req_ack, 4'b1000); chk("bp_b2b_grant", rnd_ready, 1);
        cyc(); req_valid = 4'b0001; rnd_valid = 1'b0;
        cyc(); smp(); chk("bp_next_id", out_id, 0); chk("bp_next_ack", req_ack, 4'b0001);
        cyc(); req_valid = '0; out_ready = 1'b0;
        cyc();

        // RNG starvation.
        req_valid = 4'b0001; rnd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            smp(); chk("starve_no_rnd", rnd_ready, 0); chk("starve_no_valid", out_valid, 0);
            cyc();
        end
        rnd_valid = 1'b1; rnd_data = 4'b0001;
        smp(); chk("starve_grant", rnd_ready, 1);
        cyc(); rnd_valid = 1'b0;
        cyc(); smp(); chk("starve_valid", out_valid, 1); chk("starve_id", out_id, 0);
        chk("starve_data", out_data, 12'hFFF);
        cyc(); out_ready = 1'b1;
        smp(); chk("starve_ack", req_ack, 4'b0001);
        cyc(); req_valid = '0; out_ready = 1'b0;

        // Reset while encoding; the requester keeps asking and is served again.
        req_valid = 4'b0010; rnd_valid = 1'b1; rnd_data = 4'b0111;
        smp(); chk("rse_grant", rnd_ready, 1);
        cyc(); rnd_valid = 1'b0;
        smp(); chk("rse_enc_r", enc_r, 4'b0111);
        #2 rst_n = 1'b0;
        #1 chk("rse_async_valid", out_valid, 0); chk("rse_async_enc_r", enc_r, 0);
        chk("rse_async_count", enc_count, 0); chk("rse_async_ack", req_ack, 0);
        smp();
        cyc(); rst_n = 1'b1;
        serve(4'b0010, 4'b1001, 12'hFFF, 1, "rerun");
        chk("rerun_count", enc_count, 1);

        // Randomized traffic; requesters hold until acked.
        rq = '0;
        for (int c = 0; c < 2000; c++) begin
            cyc();
            for (int i = 0; i < N_REQ; i++) begin
                if (last_ack[i]) rq[i] = 1'b0;
                else if (!rq[i] && $urandom_range(3) == 0) rq[i] = 1'b1;
            end
            req_valid = rq;
            rnd_valid = ($urandom_range(3) != 0);
            rnd_data  = 4'($urandom);
            out_ready = ($urandom_range(2) != 0);
        end
        cyc(); req_valid = '0; rnd_valid = 1'b0; out_ready = 1'b1;
        smp(); smp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
